// File: rtl/gpu_isa_pkg.sv
// Shared ISA definitions for the controller and the program loader.
// Holds the instruction geometry, the 4-bit opcode encoding and a helper that
// extracts the opcode field from the most significant nibble of an instruction.
package gpu_isa_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned OPCODE_WIDTH      = 4;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_NOP  = 4'h0,
    OP_END  = 4'h1,
    OP_XOR  = 4'h2,
    OP_ADDI = 4'h3,
    OP_BGE  = 4'h4,
    OP_JUMP = 4'h5
  } opcode_e;

  function automatic logic [OPCODE_WIDTH-1:0] opcode_of(
    input logic [INSTRUCTION_WIDTH-1:0] instr
  );
    return instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream + instruction-buffer write port of the program loader.
//   byte_in / byte_valid_in / byte_ready_out : valid/ready byte stream from the host link
//   wr_addr_out / wr_data_out / wr_en_out    : BRAM write port
// Modport slave is the loader side; modport master is the host/BRAM side.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [7:0]            byte_in;
  logic                  byte_valid_in;
  logic                  byte_ready_out;
  logic [ADDR_WIDTH-1:0] wr_addr_out;
  logic [DATA_WIDTH-1:0] wr_data_out;
  logic                  wr_en_out;

  modport slave (
    input  byte_in, byte_valid_in,
    output byte_ready_out, wr_addr_out, wr_data_out, wr_en_out
  );

  modport master (
    output byte_in, byte_valid_in,
    input  byte_ready_out, wr_addr_out, wr_data_out, wr_en_out
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit instructions.
//   clk_in, rst_in  : clock, asynchronous active-high reset
//   clear_i         : restart packing at byte 0
//   byte_i          : stream byte
//   byte_accept_i   : byte_i is consumed this cycle
//   word_o          : word as it stands once the current byte is shifted in
//   word_valid_o    : this cycle's accepted byte completes a word
module program_loader_word_assembler (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_accept_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_o       = {word_q[23:0], byte_i};
    word_valid_o = byte_accept_i && (cnt_q == 2'd3);
    word_d       = word_q;
    cnt_d        = cnt_q;
    if (clear_i) begin
      cnt_d = 2'd0;
    end else if (byte_accept_i) begin
      word_d = word_o;
      // Wraps back to 0 on the 4th byte.
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a program from a byte stream into the controller's instruction BRAM.
//   clk_in, rst_in      : clock, asynchronous active-high reset
//   load_start_in       : pulse that starts a load (only honoured when idle)
//   bus                 : byte stream in, BRAM write port out
//   controller_rst_out  : holds the controller in reset while loading
//   loading_out         : load in progress
//   done_out            : one-cycle pulse at the end of a load
//   error_out           : sticky, buffer filled without an END instruction
//   words_loaded_out    : instructions written by the last/current load
// Every output is a flop; the next values are decoded from the next state.
module program_loader #(
  parameter int unsigned INSTRUCTION_WIDTH = gpu_isa_pkg::INSTRUCTION_WIDTH,
  parameter int unsigned INSTRUCTION_COUNT = 20,
  parameter int unsigned ADDR_WIDTH        = $clog2(INSTRUCTION_COUNT)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  load_start_in,
  program_loader_if.slave       bus,
  output logic                  controller_rst_out,
  output logic                  loading_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [ADDR_WIDTH:0]   words_loaded_out
);

  import gpu_isa_pkg::OP_END;
  import gpu_isa_pkg::opcode_of;

  typedef enum logic [1:0] {StIdle, StRecv, StWrite, StDone} state_e;

  localparam logic [ADDR_WIDTH:0] LastIdx = (ADDR_WIDTH + 1)'(INSTRUCTION_COUNT - 1);

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH:0]          word_count_q, word_count_d;
  logic                         error_q, error_d;
  logic [ADDR_WIDTH-1:0]        wr_addr_q, wr_addr_d;
  logic [INSTRUCTION_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                         byte_ready_q, wr_en_q, done_q, loading_q;

  logic        start;
  logic        accept;
  logic [31:0] word;
  logic        word_valid;

  assign start  = load_start_in && (state_q == StIdle);
  // byte_ready_q is high exactly in StRecv, so this is the only place bytes are taken.
  assign accept = bus.byte_valid_in && byte_ready_q;

  program_loader_word_assembler u_word_assembler (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .clear_i       (start),
    .byte_i        (bus.byte_in),
    .byte_accept_i (accept),
    .word_o        (word),
    .word_valid_o  (word_valid)
  );

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    error_d      = error_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    unique case (state_q)
      StIdle: begin
        if (load_start_in) begin
          word_count_d = '0;
          error_d      = 1'b0;
          state_d      = StRecv;
        end
      end
      StRecv: begin
        if (word_valid) begin
          wr_addr_d = word_count_q[ADDR_WIDTH-1:0];
          wr_data_d = word;
          state_d   = StWrite;
        end
      end
      StWrite: begin
        word_count_d = word_count_q + 1'b1;
        if (opcode_of(wr_data_q) == OP_END) begin
          state_d = StDone;
        end else if (word_count_q == LastIdx) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StRecv;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= StIdle;
      word_count_q <= '0;
      error_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      done_q       <= 1'b0;
      loading_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      error_q      <= error_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      byte_ready_q <= (state_d == StRecv);
      wr_en_q      <= (state_d == StWrite);
      done_q       <= (state_d == StDone);
      loading_q    <= (state_d == StRecv) || (state_d == StWrite);
    end
  end

  assign bus.byte_ready_out = byte_ready_q;
  assign bus.wr_en_out      = wr_en_q;
  assign bus.wr_addr_out    = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign controller_rst_out = loading_q;
  assign loading_out        = loading_q;
  assign done_out           = done_q;
  assign error_out          = error_q;
  assign words_loaded_out   = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a small buffer (4 instructions).
// Expected BRAM writes are queued as words are sent and popped by a write monitor.
module tb_program_loader;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ctrl_rst, loading, done, error;
  logic [AW:0] words;

  int tests = 0;
  int fails = 0;
  int exp_addr = 0;
  bit gaps = 1'b0;
  wr_t exp_q[$];

  program_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  program_loader #(.INSTRUCTION_COUNT(N)) dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .load_start_in      (start),
    .bus                (bus),
    .controller_rst_out (ctrl_rst),
    .loading_out        (loading),
    .done_out           (done),
    .error_out          (error),
    .words_loaded_out   (words)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every BRAM write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.wr_en_out) begin
      wr_t e;
      check("wr_ready_low", {63'd0, bus.byte_ready_out}, 64'd0);
      check("wr_expected", {63'd0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", {62'd0, bus.wr_addr_out}, {62'd0, e.addr});
        check("wr_data", {32'd0, bus.wr_data_out}, {32'd0, e.data});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if (gaps) begin
      bus.byte_valid_in = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    bus.byte_in       = b;
    bus.byte_valid_in = 1'b1;
    while (!bus.byte_ready_out && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept_in_time", {63'd0, n < 40}, 64'd1);
    @(posedge clk);
    #1 bus.byte_valid_in = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] w);
    wr_t e;
    e.addr = AW'(exp_addr);
    e.data = w;
    exp_q.push_back(e);
    exp_addr++;
  endtask

  task automatic send_word(input logic [31:0] w);
    push_exp(w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic start_load();
    @(negedge clk);
    start    = 1'b1;
    exp_addr = 0;
    @(negedge clk);
    start = 1'b0;
    check("start_ready", {63'd0, bus.byte_ready_out}, 64'd1);
    check("start_error_clr", {63'd0, error}, 64'd0);
    check("start_words_clr", {61'd0, words}, 64'd0);
    check("start_ctrl_rst", {63'd0, ctrl_rst}, 64'd1);
  endtask

  task automatic wait_done(input int exp_words, input logic exp_err);
    int   n;
    logic prev;
    n    = 0;
    prev = 1'b0;
    while (!done && n < 40) begin
      prev = bus.wr_en_out;
      @(negedge clk);
      n++;
    end
    check("done_seen", {63'd0, n < 40}, 64'd1);
    check("done_after_write", {63'd0, prev}, 64'd1);
    check("done_words", {61'd0, words}, 64'(exp_words));
    check("done_error", {63'd0, error}, {63'd0, exp_err});
    check("done_ctrl_rst", {63'd0, ctrl_rst}, 64'd0);
    check("done_loading", {63'd0, loading}, 64'd0);
    check("done_ready", {63'd0, bus.byte_ready_out}, 64'd0);
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("words_hold", {61'd0, words}, 64'(exp_words));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.byte_in       = 8'h00;
    bus.byte_valid_in = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, bus.byte_ready_out}, 64'd0);
    check("rst_wr_en", {63'd0, bus.wr_en_out}, 64'd0);
    check("rst_wr_addr", {62'd0, bus.wr_addr_out}, 64'd0);
    check("rst_wr_data", {32'd0, bus.wr_data_out}, 64'd0);
    check("rst_ctrl_rst", {63'd0, ctrl_rst}, 64'd0);
    check("rst_loading", {63'd0, loading}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_error", {63'd0, error}, 64'd0);
    check("rst_words", {61'd0, words}, 64'd0);
    rst = 1'b0;

    // Three instructions ending in END.
    start_load();
    send_word(32'h301F4000);
    send_word(32'h50000000);
    send_word(32'h10000000);
    wait_done(3, 1'b0);

    // Buffer fills without END; nothing past the last slot is written.
    start_load();
    send_word(32'h00000001);
    send_word(32'h00000002);
    send_word(32'h00000003);
    send_word(32'h00000004);
    wait_done(4, 1'b1);
    @(negedge clk);
    bus.byte_in       = 8'hAA;
    bus.byte_valid_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("idle_ready_low", {63'd0, bus.byte_ready_out}, 64'd0);
    end
    bus.byte_valid_in = 1'b0;
    check("full_words_hold", {61'd0, words}, 64'd4);
    check("full_error_sticky", {63'd0, error}, 64'd1);

    // Same program with random gaps between bytes.
    gaps = 1'b1;
    start_load();
    send_word(32'h301F4000);
    send_word(32'h50000000);
    send_word(32'h10000000);
    wait_done(3, 1'b0);
    gaps = 1'b0;

    // load_start_in in the middle of a word is ignored.
    start_load();
    push_exp(32'h301F4000);
    send_byte(8'h30);
    send_byte(8'h1F);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ign_start_loading", {63'd0, loading}, 64'd1);
    check("ign_start_ready", {63'd0, bus.byte_ready_out}, 64'd1);
    send_byte(8'h40);
    send_byte(8'h00);
    send_word(32'h10000000);
    wait_done(2, 1'b0);

    // Asynchronous reset after six bytes.
    start_load();
    send_word(32'h20000000);
    send_byte(8'hAB);
    send_byte(8'hCD);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {63'd0, bus.byte_ready_out}, 64'd0);
    check("arst_wr_en", {63'd0, bus.wr_en_out}, 64'd0);
    check("arst_ctrl_rst", {63'd0, ctrl_rst}, 64'd0);
    check("arst_loading", {63'd0, loading}, 64'd0);
    check("arst_words", {61'd0, words}, 64'd0);
    check("arst_wr_data", {32'd0, bus.wr_data_out}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle_ready", {63'd0, bus.byte_ready_out}, 64'd0);
    check("post_rst_idle_loading", {63'd0, loading}, 64'd0);
    start_load();
    send_word(32'h10000000);
    wait_done(1, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
